// File: rtl/vga_fsync_pkg.sv
// Shared types and default constants for the VGA frame-boundary synchroniser.
// The optional frame counter is enabled by defining VGA_FSYNC_FRAME_CNT_EN.
package vga_fsync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_ON  = 2'd1,
        ACTIVE  = 2'd2,
        ARM_OFF = 2'd3
    } ch_state_e;

    localparam int          DEF_NUM_CH       = 4;
    localparam logic [15:0] DEF_ONESHOT_MASK = 16'h0008;
    localparam int          DEF_MIN_FRAMES   = 1;
    localparam int          DEF_FRAME_CNT_W  = 16;

    // The flag stays up in ARM_OFF so a request glitch never costs a frame.
    function automatic logic state_is_active(input ch_state_e s);
        return (s == ACTIVE) || (s == ARM_OFF);
    endfunction

endpackage

// File: rtl/vga_fsync_channel.sv
// One synchroniser channel: request FSM plus minimum-duration hold counter.
// Activity only changes on a vsync event, except for clear and ARM_OFF re-entry.
module vga_fsync_channel
    import vga_fsync_pkg::*;
#(
    parameter bit ONESHOT    = 1'b0,
    parameter int MIN_FRAMES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic vs_evt,
    input  logic req,
    input  logic clear,
    output logic active,
    output logic start,
    output logic stop
);

    localparam int              HOLD_W    = $clog2(MIN_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_FRAMES - 1);

    ch_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_d, stop_d;
    logic              active_q, start_q, stop_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            active_q <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            active_q <= state_is_active(state_d);
            start_q  <= start_d;
            stop_q   <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && vs_evt) begin
                        state_d = ACTIVE;
                        hold_d  = HOLD_LOAD;
                        start_d = 1'b1;
                    end else if (req) begin
                        state_d = ARM_ON;
                    end
                end
                ARM_ON: begin
                    if (vs_evt) begin
                        state_d = ACTIVE;
                        hold_d  = HOLD_LOAD;
                        start_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    // One-shot channels ignore vsync and req until cleared.
                    if (!ONESHOT) begin
                        if (vs_evt) begin
                            if (hold_q == '0 && !req) begin
                                state_d = IDLE;
                                stop_d  = 1'b1;
                            end else if (hold_q != '0) begin
                                hold_d = hold_q - 1'b1;
                            end
                        end else if (hold_q == '0 && !req) begin
                            state_d = ARM_OFF;
                        end
                    end
                end
                ARM_OFF: begin
                    if (vs_evt) begin
                        state_d = IDLE;
                        stop_d  = 1'b1;
                    end else if (req) begin
                        state_d = ACTIVE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign active = active_q;
    assign start  = start_q;
    assign stop   = stop_q;

endmodule

// File: rtl/vga_frame_sync_ctrl.sv
// Frame-aligned activity flags for NUM_CH pipeline channels keyed to VGA vsync.
// Define VGA_FSYNC_FRAME_CNT_EN to build the vsync event counter on o_frame_cnt.
module vga_frame_sync_ctrl
    import vga_fsync_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter logic [NUM_CH-1:0] ONESHOT_MASK = DEF_ONESHOT_MASK[NUM_CH-1:0],
    parameter int                MIN_FRAMES   = DEF_MIN_FRAMES,
    parameter int                FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_vsync,
    input  logic [NUM_CH-1:0]      i_req,
    input  logic [NUM_CH-1:0]      i_clear,
    output logic [NUM_CH-1:0]      o_active,
    output logic [NUM_CH-1:0]      o_start,
    output logic [NUM_CH-1:0]      o_stop,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    logic vs_d;
    logic vs_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= i_vsync;
        end
    end

    // A held-high vsync produces a single event on its rising edge.
    assign vs_evt = i_vsync & ~vs_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        vga_fsync_channel #(
            .ONESHOT    (ONESHOT_MASK[c]),
            .MIN_FRAMES (MIN_FRAMES)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .vs_evt  (vs_evt),
            .req     (i_req[c]),
            .clear   (i_clear[c]),
            .active  (o_active[c]),
            .start   (o_start[c]),
            .stop    (o_stop[c])
        );
    end

`ifdef VGA_FSYNC_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else if (vs_evt) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`else
    assign o_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sync_ctrl.sv
// Self-checking bench for vga_frame_sync_ctrl: vector table plus corner-case sequences.
// Expected o_frame_cnt follows VGA_FSYNC_FRAME_CNT_EN the same way the design does.
module tb_vga_frame_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic [3:0] req, clr;
    logic [3:0] active, start, stop, cnt;
    logic [3:0] active3, start3, stop3, cnt3;

    always #5 clk = ~clk;

    vga_frame_sync_ctrl #(
        .NUM_CH(4), .ONESHOT_MASK(4'b1000), .MIN_FRAMES(1), .FRAME_CNT_W(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_req(req), .i_clear(clr),
        .o_active(active), .o_start(start), .o_stop(stop), .o_frame_cnt(cnt)
    );

    // Second instance exercises the multi-frame hold; it shares all stimulus.
    vga_frame_sync_ctrl #(
        .NUM_CH(4), .ONESHOT_MASK(4'b1000), .MIN_FRAMES(3), .FRAME_CNT_W(4)
    ) dut_m3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_req(req), .i_clear(clr),
        .o_active(active3), .o_start(start3), .o_stop(stop3), .o_frame_cnt(cnt3)
    );

    typedef struct {
        logic       vs;
        logic [3:0] rq;
        logic [3:0] cl;
        logic [3:0] act;
        logic [3:0] st;
        logic [3:0] sp;
    } vec_t;

    typedef struct {
        logic [3:0] act, st, sp, cnt;
        logic       use_m3;
        logic [3:0] act3, st3, sp3;
        string      name;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_vs;
    logic [3:0] exp_cnt;

    task automatic cmp(input string name, input string field, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s.%s got=%b expected=%b", name, field, got, want);
        end
    endtask

    task automatic applyStimulus(input logic vs, input logic [3:0] r, input logic [3:0] c,
                                 input logic [3:0] a, input logic [3:0] s, input logic [3:0] p,
                                 input logic use_m3, input logic [3:0] a3, input logic [3:0] s3,
                                 input logic [3:0] p3, input string name);
        exp_t e;
        @(negedge clk);
        vsync = vs;
        req   = r;
        clr   = c;
        if (vs && !prev_vs) exp_cnt = exp_cnt + 4'd1;
        prev_vs = vs;
        e.act = a; e.st = s; e.sp = p;
        e.use_m3 = use_m3; e.act3 = a3; e.st3 = s3; e.sp3 = p3;
`ifdef VGA_FSYNC_FRAME_CNT_EN
        e.cnt = exp_cnt;
`else
        e.cnt = 4'd0;
`endif
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL scoreboard got=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "active", active, e.act);
        cmp(e.name, "start",  start,  e.st);
        cmp(e.name, "stop",   stop,   e.sp);
        cmp(e.name, "cnt",    cnt,    e.cnt);
        if (e.use_m3) begin
            cmp(e.name, "m3_active", active3, e.act3);
            cmp(e.name, "m3_start",  start3,  e.st3);
            cmp(e.name, "m3_stop",   stop3,   e.sp3);
            cmp(e.name, "m3_cnt",    cnt3,    e.cnt);
        end
    endtask

    task automatic step(input logic vs, input logic [3:0] r, input logic [3:0] c,
                        input logic [3:0] a, input logic [3:0] s, input logic [3:0] p, input string name);
        applyStimulus(vs, r, c, a, s, p, 1'b0, 4'd0, 4'd0, 4'd0, name);
        checkOutput();
    endtask

    task automatic stepM3(input logic vs, input logic [3:0] r, input logic [3:0] a, input logic [3:0] s,
                          input logic [3:0] p, input logic [3:0] a3, input logic [3:0] s3,
                          input logic [3:0] p3, input string name);
        applyStimulus(vs, r, 4'd0, a, s, p, 1'b1, a3, s3, p3, name);
        checkOutput();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        vsync = 1'b0;
        req   = '0;
        clr   = '0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        prev_vs = 1'b0;
        exp_cnt = 4'd0;
        sb.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        vsync   = 1'b0;
        req     = '0;
        clr     = '0;
        prev_vs = 1'b0;
        exp_cnt = 4'd0;

        //               vs    req      clear    active   start    stop
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0100, 4'b0000, 4'b1100, 4'b1100, 4'b0000});
        tbl.push_back('{1'b0, 4'b0100, 4'b0000, 4'b1100, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0100, 4'b0000, 4'b1100, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0100, 4'b0000, 4'b1100, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});

        doReset();
        $display("[TB] vector table: %0d rows", tbl.size());
        foreach (tbl[i]) begin
            step(tbl[i].vs, tbl[i].rq, tbl[i].cl, tbl[i].act, tbl[i].st, tbl[i].sp,
                 $sformatf("tbl%0d", i));
        end

        // Minimum hold of three frames versus one frame, req dropped right after start.
        doReset();
        stepM3(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "m3_arm");
        stepM3(1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, "m3_start");
        stepM3(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "m3_drop");
        stepM3(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "m3_ev1");
        stepM3(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "m3_gap1");
        stepM3(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "m3_ev2");
        stepM3(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "m3_gap2");
        stepM3(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "m3_ev3");
        stepM3(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "m3_after");

        // One-shot channel survives ten frames without req, then clears silently.
        doReset();
        step(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "os_arm");
        step(1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, "os_start");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, $sformatf("os_lo%0d", i));
            step(1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, $sformatf("os_hi%0d", i));
        end
        step(1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, "os_clear");
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "os_after");

        // Vsync held high for 100 cycles is a single event.
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "hold_pre");
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 4'b0001, 4'b0000, 4'b0001, (i == 0) ? 4'b0001 : 4'b0000, 4'b0000,
                 $sformatf("vs_held%0d", i));
        end
        step(1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "vs_fall");
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "vs_next");

        // Seventeen events wrap the 4-bit counter to one.
        doReset();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, $sformatf("wrap_hi%0d", i));
            step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, $sformatf("wrap_lo%0d", i));
        end
`ifdef VGA_FSYNC_FRAME_CNT_EN
        cmp("wrap_final", "cnt", cnt, 4'd1);
`else
        cmp("wrap_final", "cnt", cnt, 4'd0);
`endif

        // Asynchronous reset with start pulses and active flags high.
        step(1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_arm");
        step(1'b1, 4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b0000, "rst_start");
        rst_n = 1'b0;
        #1;
        cmp("async_rst", "active", active, 4'b0000);
        cmp("async_rst", "start",  start,  4'b0000);
        cmp("async_rst", "stop",   stop,   4'b0000);
        cmp("async_rst", "cnt",    cnt,    4'b0000);
        cmp("async_rst", "m3_active", active3, 4'b0000);
        doReset();
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_sync_ctrl.md
# vga_frame_sync_ctrl

Parametrised frame-boundary synchroniser between the CCD/processing pipeline and the VGA timing generator. Each of NUM_CH channels turns an asynchronous-in-time request (level or single-cycle pulse) into an activity flag that changes only on a VGA vertical-sync event, so downstream stages (grayscale, blob detection, overlay) always start and stop on whole frames. Channels run in level-follow or one-shot (latch-until-clear) mode, with a minimum active duration in frames and an optional frame counter.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- ONESHOT_MASK, 4'b1000, bit c = 1 makes channel c one-shot (latches active until cleared)
- MIN_FRAMES, 1, minimum frames a level-mode channel stays active once started (>= 1)
- FRAME_CNT_W, 16, width of the frame counter
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_vsync  input  1  VGA vertical sync, active-high, synchronous to i_clk
- i_req  input  NUM_CH  per-channel request; level or 1-cycle pulse
- i_clear  input  NUM_CH  per-channel synchronous clear
- o_active  output  NUM_CH  per-channel frame-aligned activity flag
- o_start  output  NUM_CH  1-cycle pulse coincident with o_active rising
- o_stop  output  NUM_CH  1-cycle pulse coincident with o_active falling via vsync
- o_frame_cnt  output  FRAME_CNT_W  count of vsync events, wraps

## Operation
- vs_evt = i_vsync & ~vs_d, vs_d = i_vsync registered (reset 0). Only rising edges count; a held-high i_vsync is one event.
- Per-channel states: IDLE, ARM_ON, ACTIVE, ARM_OFF. o_active = 1 in ACTIVE and ARM_OFF.
- hold: per-channel down-counter, width $clog2(MIN_FRAMES+1), loaded MIN_FRAMES-1 on entry to ACTIVE from ARM_ON/IDLE.
- IDLE: req & vs_evt -> ACTIVE (o_start); req & ~vs_evt -> ARM_ON.
- ARM_ON: request is sticky; req may drop. vs_evt -> ACTIVE (o_start).
- ACTIVE, one-shot channel: stays until i_clear.
- ACTIVE, level channel: on vs_evt: hold==0 & ~req -> IDLE (o_stop); else if hold>0, hold-1. Without vs_evt: hold==0 & ~req -> ARM_OFF.
- ARM_OFF: vs_evt -> IDLE (o_stop); req reasserted without vs_evt -> ACTIVE (no pulses, hold unchanged at 0).
- i_clear[c]: highest priority over every state and event; channel -> IDLE, hold -> 0, o_active drops next edge, no o_stop pulse. Clear and req in the same cycle: clear wins, req discarded.
- Channels fully independent; simultaneous events on many channels all handled in the same cycle.

## Timing
- All outputs registered. Reset values: o_active 0, o_start 0, o_stop 0, o_frame_cnt 0, all channels IDLE.
- Latency: i_vsync rising sampled at edge N -> o_active/o_start/o_stop change at edge N+1.
- req at the same edge as vs_evt in IDLE: activation on that event (1-cycle latency), no ARM_ON visit.
- Pulses are exactly one cycle; o_start and o_stop never both high for a channel.
- Level channel with req dropped immediately after start: active for exactly MIN_FRAMES vs_evts, falls on the MIN_FRAMES-th event after start.
- Reset mid-frame: all outputs to reset values immediately (async); next vs_evt needs a fresh rising edge after reset.

## Configuration
- VGA_FSYNC_FRAME_CNT_EN defined: o_frame_cnt increments by 1 on every vs_evt, wraps 2^FRAME_CNT_W-1 -> 0.
- Not defined: counter logic removed, o_frame_cnt tied to 0; channel behaviour unchanged.

## Structure
- Package vga_fsync_pkg: ch_state_e enum (IDLE, ARM_ON, ACTIVE, ARM_OFF), default parameter constants.
- Sub-module vga_fsync_channel: one channel FSM + hold counter, ONESHOT and MIN_FRAMES as parameters, instantiated NUM_CH times by generate. Top holds vsync edge detect and frame counter.

## Test plan
- Level start/stop, MIN_FRAMES=1: req[0]=1 mid-frame -> o_active[0] rises 1 cycle after next vsync rise with o_start[0]; req[0]=0 -> falls 1 cycle after following vsync rise with o_stop[0].
- Pulse request: 1-cycle req[1] between vsyncs -> ARM_ON holds it; active at next vsync, off at the one after.
- MIN_FRAMES=3: start then immediately drop req -> o_active high across exactly 3 vsync events, o_stop on the 3rd.
- One-shot ch3: req pulse -> active at next vsync, stays through 10 vsyncs with req=0; i_clear[3] -> o_active 0 next cycle, no o_stop.
- Corner events: req with vsync rise same cycle -> o_active next cycle; req re-raised in ARM_OFF -> no pulses, stays active; i_vsync held high 100 cycles -> one event, o_frame_cnt +1.
- Wrap/reset: FRAME_CNT_W=4, 17 vsyncs -> o_frame_cnt 1; assert i_rst_n=0 with channels active -> all outputs 0 immediately.
